// File: rtl/fetch_pc_gen.sv
// ---------------------------------------------------------------------------
// fetch_pc_gen
//
// Front end of the fetch stage. Owns the fetch PC, issues single-word reads
// to instruction memory over a req/gnt/rvalid handshake (at most one read
// outstanding), and presents each returned instruction together with its PC
// to the decode pipeline register. Decode stalls hold the presented entry;
// branch/jump redirects flush it and discard any read still in flight.
//
// Parameters
//   PC_W      PC / address width (instruction data is always 32 bits)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   stall_d          decode stall, holds the current if_* entry
//   redirect_valid   taken branch/jump this cycle
//   redirect_pc      redirect target
//   imem_req/addr    read request (combinational) and address (= fetch PC)
//   imem_gnt         request accepted when imem_req & imem_gnt
//   imem_rvalid/data read response
//   if_valid         if_pc / if_instr hold a valid instruction
//   if_pc            PC of the presented instruction
//   if_pc_plus4      if_pc + 4, wrapping
//   if_instr         presented instruction
//   fetch_misalign   (FETCH_ALIGN_CHECK_EN only) misaligned redirect seen
//
// Build option
//   FETCH_ALIGN_CHECK_EN  when defined, a redirect to a non word-aligned
//   target raises fetch_misalign and blocks fetching until an aligned
//   redirect arrives. When undefined, the low two target bits are dropped.
// ---------------------------------------------------------------------------
module fetch_pc_gen #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0040_0020
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_d,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    output logic [PC_W-1:0] if_pc,
    output logic [PC_W-1:0] if_pc_plus4,
    output logic [31:0]     if_instr
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic            fetch_misalign
`endif
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } state_e;

    localparam logic [PC_W-1:0] ALIGN_MASK = {{(PC_W-2){1'b1}}, 2'b00};
    localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);

    state_e          state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] req_pc_q, req_pc_d;
    logic            if_valid_q, if_valid_d;
    logic [PC_W-1:0] if_pc_q, if_pc_d;
    logic [31:0]     if_instr_q, if_instr_d;

    logic [PC_W-1:0] redir_target_s;
    logic            misalign_s;
    logic            req_s;
    logic            grant_s;

    // Redirect targets are always word aligned internally.
    assign redir_target_s = redirect_pc & ALIGN_MASK;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;
    logic redir_misalign_s;

    assign redir_misalign_s = |redirect_pc[1:0];
    assign misalign_s       = misalign_q;
    assign fetch_misalign   = misalign_q;

    // Misalign flag is replaced on every redirect and held otherwise.
    always_comb begin
        misalign_d = misalign_q;
        if (redirect_valid) begin
            misalign_d = redir_misalign_s;
        end else begin
            misalign_d = misalign_q;
        end
    end

    // Misalign flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`else
    assign misalign_s = 1'b0;
`endif

    // A request is only issued when the output slot is free or being drained,
    // which is what guarantees a response never meets a stalled full slot.
    assign req_s   = (state_q == S_REQ) & ~redirect_valid
                   & (~if_valid_q | ~stall_d) & ~misalign_s;
    assign grant_s = req_s & imem_gnt;

    // Next-state logic for the FSM, fetch PC and decode-facing entry.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;

        // Consume: the entry leaves when decode is not stalling.
        if (if_valid_q && !stall_d) begin
            if_valid_d = 1'b0;
        end else begin
            if_valid_d = if_valid_q;
        end

        if (redirect_valid) begin
            // Flush wins over stall and over any load this cycle.
            fetch_pc_d = redir_target_s;
            if_valid_d = 1'b0;
            case (state_q)
                S_WAIT, S_DROP: begin
                    // A response landing now is simply discarded.
                    state_d = imem_rvalid ? S_REQ : S_DROP;
                end
                default: begin
                    state_d = grant_s ? S_DROP : S_REQ;
                end
            endcase
        end else begin
            case (state_q)
                S_BOOT: begin
                    state_d = S_REQ;
                end
                S_REQ: begin
                    if (grant_s) begin
                        req_pc_d   = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + PC_STEP;
                        state_d    = S_WAIT;
                    end else begin
                        state_d    = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = req_pc_q;
                        if_instr_d = imem_rdata;
                        state_d    = S_REQ;
                    end else begin
                        state_d    = S_WAIT;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_DROP;
                    end
                end
                default: begin
                    state_d = S_BOOT;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_BOOT;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

    assign imem_req    = req_s;
    assign imem_addr   = fetch_pc_q;
    assign if_valid    = if_valid_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_q + PC_STEP;
    assign if_instr    = if_instr_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc_gen
//
// Directed-vector bench for fetch_pc_gen. A small instruction-memory model
// answers each granted read after a programmable number of cycles with
// data derived from the address (or a poisoned word on request). Each test
// task drives its scenario and compares outputs against hand-derived values.
// ---------------------------------------------------------------------------
module tb_fetch_pc_gen;

    localparam logic [31:0] RST_PC = 32'h0040_0020;
    localparam logic [31:0] POISON = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_d = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0000_0000;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0000_0000;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instr;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    int n_vec = 0;
    int n_err = 0;

    // memory model state
    bit          fire_s = 1'b0;
    logic [31:0] addr_s = 32'h0;
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;
    int          mem_lat = 1;
    bit          poison = 1'b0;

    fetch_pc_gen #(.PC_W(32), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_d        (stall_d),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .if_instr       (if_instr)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_misalign (fetch_misalign)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Handshake sampled mid-cycle, away from the clock edge.
    initial forever begin
        @(negedge clk);
        fire_s = rst_n & imem_req & imem_gnt;
        addr_s = imem_addr;
    end

    // Memory responder: answers mem_lat cycles after the grant cycle.
    initial forever begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            pend        = 1'b0;
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
            if (fire_s) begin
                pend      = 1'b1;
                pend_cnt  = mem_lat;
                pend_addr = addr_s;
            end
            if (pend) begin
                pend_cnt = pend_cnt - 1;
                if (pend_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = poison ? POISON : mem_word(pend_addr);
                    poison      = 1'b0;
                    pend        = 1'b0;
                end
            end
        end
    end

    task automatic wait_valid(input int max_cyc, output bit got);
        got = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (if_valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b expected 0", imem_req); end
        n_vec++; if (imem_addr !== RST_PC) begin n_err++; $display("FAIL rst_addr: got %h expected %h", imem_addr, RST_PC); end
        n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", if_valid); end
        n_vec++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h expected 0", if_pc); end
        n_vec++; if (if_instr !== 32'h0) begin n_err++; $display("FAIL rst_instr: got %h expected 0", if_instr); end
        n_vec++; if (if_pc_plus4 !== 32'h4) begin n_err++; $display("FAIL rst_plus4: got %h expected 4", if_pc_plus4); end
`ifdef FETCH_ALIGN_CHECK_EN
        n_vec++; if (fetch_misalign !== 1'b0) begin n_err++; $display("FAIL rst_misalign: got %b expected 0", fetch_misalign); end
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL boot_idle: got req %b expected 0", imem_req); end
        @(negedge clk);
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            n_err++; $display("FAIL first_req: got req %b addr %h expected 1 %h", imem_req, imem_addr, RST_PC);
        end
    endtask

    task automatic test_sequential;
        bit got;
        logic [31:0] exp_pc;
        for (int k = 0; k < 3; k++) begin
            exp_pc = RST_PC + 32'(4 * k);
            wait_valid(8, got);
            n_vec++;
            if (!got) begin n_err++; $display("FAIL seq_timeout: got no if_valid expected pc %h", exp_pc); end
            else if (if_pc !== exp_pc || if_instr !== mem_word(exp_pc) || if_pc_plus4 !== exp_pc + 32'h4) begin
                n_err++; $display("FAIL seq_entry: got pc %h instr %h plus4 %h expected %h %h %h",
                                  if_pc, if_instr, if_pc_plus4, exp_pc, mem_word(exp_pc), exp_pc + 32'h4);
            end
        end
    endtask

    task automatic test_gnt_hold;
        bit found;
        @(posedge clk); #1;
        imem_gnt = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h0040_0030) begin found = 1'b1; break; end
        end
        n_vec++; if (!found) begin n_err++; $display("FAIL hold_find: got addr %h expected 00400030", imem_addr); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0030) begin
                n_err++; $display("FAIL hold_req: got req %b addr %h expected 1 00400030", imem_req, imem_addr);
            end
        end
    endtask

    task automatic test_redirect_on_grant;
        bit got;
        @(posedge clk); #1;
        imem_gnt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0040_0300;
        @(negedge clk);
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rgnt_req: got %b expected 0", imem_req); end
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0300) begin
            n_err++; $display("FAIL rgnt_addr: got req %b addr %h expected 1 00400300", imem_req, imem_addr);
        end
        wait_valid(8, got);
        n_vec++; if (!got || if_pc !== 32'h0040_0300 || if_instr !== mem_word(32'h0040_0300)) begin
            n_err++; $display("FAIL rgnt_entry: got valid %b pc %h instr %h expected 1 00400300 %h",
                              got, if_pc, if_instr, mem_word(32'h0040_0300));
        end
    endtask

    task automatic test_stall;
        bit got;
        @(posedge clk); #1;
        stall_d = 1'b1;
        wait_valid(8, got);
        n_vec++; if (!got || if_pc !== 32'h0040_0304) begin
            n_err++; $display("FAIL stall_entry: got valid %b pc %h expected 1 00400304", got, if_pc);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++; if (if_valid !== 1'b1 || if_pc !== 32'h0040_0304 || if_instr !== mem_word(32'h0040_0304) || imem_req !== 1'b0) begin
                n_err++; $display("FAIL stall_hold: got valid %b pc %h instr %h req %b expected 1 00400304 %h 0",
                                  if_valid, if_pc, if_instr, imem_req, mem_word(32'h0040_0304));
            end
        end
        @(posedge clk); #1;
        stall_d = 1'b0;
        @(negedge clk);
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0308) begin
            n_err++; $display("FAIL stall_resume: got req %b addr %h expected 1 00400308", imem_req, imem_addr);
        end
        wait_valid(8, got);
        n_vec++; if (!got || if_pc !== 32'h0040_0308) begin
            n_err++; $display("FAIL stall_next: got valid %b pc %h expected 1 00400308", got, if_pc);
        end
        wait_valid(8, got);
        n_vec++; if (!got || if_pc !== 32'h0040_030C) begin
            n_err++; $display("FAIL stall_next2: got valid %b pc %h expected 1 0040030c", got, if_pc);
        end
    endtask

    task automatic test_redirect_wait;
        bit got;
        // read of 00400310 is being granted now: make it slow and poisoned
        mem_lat = 3;
        poison  = 1'b1;
        @(posedge clk); #1;
        redirect_valid = 1'b1; redirect_pc = 32'h0040_0100;
        @(negedge clk);
        n_vec++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
            n_err++; $display("FAIL rwait_flush: got req %b valid %b expected 0 0", imem_req, if_valid);
        end
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        mem_lat = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++; if (if_valid !== 1'b0 || if_instr === POISON) begin
                n_err++; $display("FAIL rwait_drop: got valid %b instr %h expected 0 and not deadbeef", if_valid, if_instr);
            end
        end
        wait_valid(8, got);
        n_vec++; if (!got || if_pc !== 32'h0040_0100 || if_instr !== mem_word(32'h0040_0100)) begin
            n_err++; $display("FAIL rwait_entry: got valid %b pc %h instr %h expected 1 00400100 %h",
                              got, if_pc, if_instr, mem_word(32'h0040_0100));
        end
    endtask

    task automatic test_redirect_rvalid;
        bit got;
        @(posedge clk); #1;
        redirect_valid = 1'b1; redirect_pc = 32'h0040_0500;
        @(negedge clk);
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rrv_req: got %b expected 0", imem_req); end
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0500 || if_valid !== 1'b0) begin
            n_err++; $display("FAIL rrv_next: got req %b addr %h valid %b expected 1 00400500 0", imem_req, imem_addr, if_valid);
        end
        wait_valid(8, got);
        n_vec++; if (!got || if_pc !== 32'h0040_0500) begin
            n_err++; $display("FAIL rrv_entry: got valid %b pc %h expected 1 00400500", got, if_pc);
        end
    endtask

    task automatic test_align;
        bit got;
        @(posedge clk); #1;
        redirect_valid = 1'b1; redirect_pc = 32'h0040_0102;
        @(negedge clk);
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL align_redir_req: got %b expected 0", imem_req); end
        @(posedge clk); #1;
        redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++; if (fetch_misalign !== 1'b1 || imem_req !== 1'b0) begin
                n_err++; $display("FAIL align_block: got misalign %b req %b expected 1 0", fetch_misalign, imem_req);
            end
        end
        @(posedge clk); #1;
        redirect_valid = 1'b1; redirect_pc = 32'h0040_0200;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (fetch_misalign !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0040_0200) begin
            n_err++; $display("FAIL align_clear: got misalign %b req %b addr %h expected 0 1 00400200",
                              fetch_misalign, imem_req, imem_addr);
        end
        wait_valid(8, got);
        n_vec++; if (!got || if_pc !== 32'h0040_0200) begin
            n_err++; $display("FAIL align_entry: got valid %b pc %h expected 1 00400200", got, if_pc);
        end
`else
        @(negedge clk);
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0100) begin
            n_err++; $display("FAIL align_force: got req %b addr %h expected 1 00400100", imem_req, imem_addr);
        end
        wait_valid(8, got);
        n_vec++; if (!got || if_pc !== 32'h0040_0100 || if_instr !== mem_word(32'h0040_0100)) begin
            n_err++; $display("FAIL align_entry: got valid %b pc %h instr %h expected 1 00400100 %h",
                              got, if_pc, if_instr, mem_word(32'h0040_0100));
        end
`endif
    endtask

    task automatic test_wrap;
        bit got;
        @(posedge clk); #1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        wait_valid(8, got);
        n_vec++; if (!got || if_pc !== 32'hFFFF_FFFC || if_pc_plus4 !== 32'h0) begin
            n_err++; $display("FAIL wrap_plus4: got valid %b pc %h plus4 %h expected 1 fffffffc 0", got, if_pc, if_pc_plus4);
        end
        n_vec++; if (imem_addr !== 32'h0) begin
            n_err++; $display("FAIL wrap_addr: got %h expected 0", imem_addr);
        end
    endtask

    task automatic test_reset_mid_wait;
        bit got;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_vec++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0 || if_pc_plus4 !== 32'h4) begin
            n_err++; $display("FAIL mrst_if: got valid %b pc %h instr %h plus4 %h expected 0 0 0 4",
                              if_valid, if_pc, if_instr, if_pc_plus4);
        end
        n_vec++; if (imem_req !== 1'b0 || imem_addr !== RST_PC) begin
            n_err++; $display("FAIL mrst_mem: got req %b addr %h expected 0 %h", imem_req, imem_addr, RST_PC);
        end
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL mrst_boot: got req %b expected 0", imem_req); end
        @(negedge clk);
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            n_err++; $display("FAIL mrst_first: got req %b addr %h expected 1 %h", imem_req, imem_addr, RST_PC);
        end
        wait_valid(8, got);
        n_vec++; if (!got || if_pc !== RST_PC || if_instr !== mem_word(RST_PC)) begin
            n_err++; $display("FAIL mrst_entry: got valid %b pc %h instr %h expected 1 %h %h",
                              got, if_pc, if_instr, RST_PC, mem_word(RST_PC));
        end
    endtask

    initial begin
        test_reset;
        test_sequential;
        test_gnt_hold;
        test_redirect_on_grant;
        test_stall;
        test_redirect_wait;
        test_redirect_rvalid;
        test_align;
        test_wrap;
        test_reset_mid_wait;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
